// File: rtl/bsm_operand_feeder.sv
// rtl/bsm_operand_feeder.sv - operand serializer and result collector for the bit-serial multiplier
module bsm_operand_feeder #(
    parameter int DW      = 32,
    parameter int WW      = 5,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic [WW-1:0] in_wa,
    input  logic [WW-1:0] in_wb,
    output logic          bsm_start,
    output logic [WW-1:0] bsm_wa,
    output logic [WW-1:0] bsm_wb,
    output logic          bsm_bitA,
    output logic          bsm_bitB,
    input  logic [DW-1:0] bsm_o,
    input  logic          bsm_done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_o,
    output logic          out_err
);

    localparam int KW = $clog2(DW);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d;
    logic [WW-1:0] wa_q, wa_d, wb_q, wb_d;
    logic [KW-1:0] k_q, k_d, k_nx;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          start_q, start_d;
    logic          bita_q, bita_d, bitb_q, bitb_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_o_q, out_o_d;
    logic          out_err_q, out_err_d;
    logic          widths_ok;

    // Bit k of a w-bit signed value; positions at or above w repeat the sign bit.
    function automatic logic ext_bit(input logic [DW-1:0] v, input logic [WW-1:0] w,
                                     input logic [KW-1:0] k);
        logic [KW-1:0] top;
        top = KW'(w) - 1'b1;
        ext_bit = (KW'(w) > k) ? v[k] : v[top];
    endfunction

    assign widths_ok = (in_wa != '0) && (in_wb != '0) &&
                       ((32'(in_wa) + 32'(in_wb)) <= 32'(DW));

    assign k_nx = (k_q == KW'(DW - 1)) ? k_q : k_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        wa_d        = wa_q;
        wb_d        = wb_q;
        k_d         = k_q;
        tmo_d       = tmo_q;
        start_d     = 1'b0;
        bita_d      = bita_q;
        bitb_d      = bitb_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_o_d     = out_o_q;
        out_err_d   = out_err_q;
        case (state_q)
            S_IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    in_ready_d = 1'b0;
                    a_d        = in_a;
                    b_d        = in_b;
                    if (widths_ok) begin
                        wa_d    = in_wa;
                        wb_d    = in_wb;
                        k_d     = '0;
                        tmo_d   = '0;
                        start_d = 1'b1;
                        bita_d  = ext_bit(in_a, in_wa, '0);
                        bitb_d  = ext_bit(in_b, in_wb, '0);
                        state_d = S_START;
                    end else begin
                        out_valid_d = 1'b1;
                        out_err_d   = 1'b1;
                        out_o_d     = '0;
                        state_d     = S_RESP;
                    end
                end
            end
            S_START: begin
                // Bit 0 stays on the wire for the first SHIFT cycle as well.
                tmo_d   = tmo_q + 1'b1;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (bsm_done) begin
                    out_valid_d = 1'b1;
                    out_err_d   = 1'b0;
                    out_o_d     = bsm_o;
                    bita_d      = 1'b0;
                    bitb_d      = 1'b0;
                    state_d     = S_RESP;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    out_valid_d = 1'b1;
                    out_err_d   = 1'b1;
                    out_o_d     = '0;
                    bita_d      = 1'b0;
                    bitb_d      = 1'b0;
                    state_d     = S_RESP;
                end else begin
                    k_d    = k_nx;
                    tmo_d  = tmo_q + 1'b1;
                    bita_d = ext_bit(a_q, wa_q, k_nx);
                    bitb_d = ext_bit(b_q, wb_q, k_nx);
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            wa_q        <= '0;
            wb_q        <= '0;
            k_q         <= '0;
            tmo_q       <= '0;
            start_q     <= 1'b0;
            bita_q      <= 1'b0;
            bitb_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_o_q     <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            wa_q        <= wa_d;
            wb_q        <= wb_d;
            k_q         <= k_d;
            tmo_q       <= tmo_d;
            start_q     <= start_d;
            bita_q      <= bita_d;
            bitb_q      <= bitb_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_o_q     <= out_o_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign bsm_start = start_q;
    assign bsm_wa    = wa_q;
    assign bsm_wb    = wb_q;
    assign bsm_bitA  = bita_q;
    assign bsm_bitB  = bitb_q;
    assign out_valid = out_valid_q;
    assign out_o     = out_o_q;
    assign out_err   = out_err_q;

endmodule

// File: doc/bsm_operand_feeder.md
Name: bsm_operand_feeder

Overview:
Upstream stage of the bit-serial multiplier (BSM). It accepts parallel signed operand pairs and their widths over a valid/ready handshake, and issues the BSM start pulse. It then drives bitAin/bitBin LSB-first with sign extension, captures O when the multiplier reports done, and returns the product on a valid/ready output port. It replaces the ad-hoc operand driving used around BSM so that a packed datapath can issue back-to-back multiplies.

Parameters:
DW, 32, operand and product width
WW, 5, width-field width (carries WA/WB to BSM)
TIMEOUT, 64, max cycles from bsm_start to bsm_done before abort

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  operand request valid
in_ready  output  1  feeder can accept request
in_a  input  DW  signed operand A
in_b  input  DW  signed operand B
in_wa  input  WW  significant width of A
in_wb  input  WW  significant width of B
bsm_start  output  1  one-cycle start pulse to BSM
bsm_wa  output  WW  registered WA to BSM
bsm_wb  output  WW  registered WB to BSM
bsm_bitA  output  1  serial bit of A
bsm_bitB  output  1  serial bit of B
bsm_o  input  DW  BSM product
bsm_done  input  1  BSM result valid (one cycle)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_o  output  DW  signed product
out_err  output  1  1 = illegal widths or timeout; out_o=0

Behaviour:
- Reset (rst=0, async): state IDLE. in_ready=0 while in reset, 1 the first cycle after release. bsm_start=0, bsm_bitA=bsm_bitB=0, bsm_wa=bsm_wb=0, out_valid=0, out_o=0, out_err=0. Bit counter and timeout counter are 0.
- States: IDLE, START, SHIFT, RESP.
- IDLE: in_ready=1. On in_valid&&in_ready, register a, b, wa and wb.
  - Widths legal (wa>=1, wb>=1, wa+wb<=DW): go to START.
  - Otherwise: go to RESP with out_err=1, out_o=0, and no BSM transaction.
- START (1 cycle): bsm_start=1, bit counter k=0, bsm_bitA/B present bit 0. Next state SHIFT.
- SHIFT: each cycle present bit k, then k<=k+1. Bit k of A is a[k] for k<wa, else a[wa-1] (sign extension). B is handled the same way with wb. k saturates at DW-1.
- Outputs are registered: bit k is visible in cycle start+1+k; bit 0 is also held during the START cycle.
- On bsm_done in SHIFT: capture out_o=bsm_o, out_err=0, go to RESP.
- Timeout counter counts cycles from START. If it reaches TIMEOUT without bsm_done: go to RESP with out_err=1, out_o=0, and bitA/bitB driven to 0.
- A bsm_done arriving outside SHIFT is ignored.
- RESP: out_valid=1 and out_o/out_err are held stable until out_ready. On the handshake: out_valid<=0, go to IDLE.
  - in_ready stays 0 in RESP, so the next request is accepted no earlier than the cycle after the output handshake.
  - Peak throughput: one multiply per (BSM latency + 3) cycles.
- Simultaneous in_valid and out_ready in RESP: only the output handshake completes.
- Reset mid-operation: aborts immediately with no output produced. bsm_start stays 0 through reset, and any pending BSM result is discarded.
- Sign/width: out_o is passed through unmodified from bsm_o.

Test Plan:
- A=15, B=-7, wa=8, wb=15, out_ready=1 -> one bsm_start pulse; bitA sequence 1,1,1,1,0,0,0,0 then 0s; out_o=-105, out_err=0.
- Back-to-back requests (A=-128,B=127,wa=8,wb=8) then (A=3,B=-1,wa=3,wb=2) -> out_o=-16256 then -3; in_ready low between them; exactly two start pulses.
- Hold out_ready=0 for 10 cycles after result -> out_valid and out_o stable for all 10 cycles; in_ready=0; completes on the first cycle with out_ready=1.
- Illegal widths (wa=0, or wa=20 with wb=15) -> no bsm_start; out_valid the next cycle with out_err=1, out_o=0.
- bsm_done tied low, TIMEOUT=64 -> out_valid exactly 64 cycles after bsm_start with out_err=1; feeder returns to IDLE.
- rst asserted mid-SHIFT, then released -> all outputs reset asynchronously; no out_valid; the next request completes correctly (A=-5, B=6 -> -30).
